// File: rtl/count_inliers.sv
// count_inliers: multi-lane plane-inlier counter for RANSAC hypothesis scoring.
// A batch of beats is tested against one latched plane; one result per batch.
module count_inliers #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FBITS       = 16,
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ivalid,
  output logic                         iready,
  input  logic                         ilast,
  input  logic [LANES-1:0]             lane_valid,
  input  logic [LANES*3*WIDTH-1:0]     p,
  input  logic [3*WIDTH-1:0]           n,
  input  logic [WIDTH-1:0]             d,
  input  logic [WIDTH-1:0]             t,
  output logic                         ovalid,
  input  logic                         oacknowledge,
  output logic [COUNT_WIDTH-1:0]       count,
  output logic [COUNT_WIDTH-1:0]       total,
  output logic                         saturated
);

  localparam int unsigned PW  = 2 * WIDTH;           // product width
  localparam int unsigned SW  = PW + 2;              // sum-of-products width
  localparam int unsigned RW  = PW + 3;              // residual width (sum minus offset)
  localparam int unsigned PCW = $clog2(LANES + 1);   // popcount width
  localparam int unsigned AW  = COUNT_WIDTH + PCW + 1;

  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic                     w_accept;
  logic                     w_start;

  logic signed [WIDTH-1:0]  r_n [3];
  logic [WIDTH-1:0]         r_d;
  logic [WIDTH-1:0]         r_t;

  logic                     r_v0, r_v1, r_v2;
  logic [LANES-1:0]         r_lv0, r_lv1, r_lv2, r_in2;
  logic [LANES*3*WIDTH-1:0] r_p0;
  logic signed [WIDTH-1:0]  w_pt   [LANES][3];
  logic signed [PW-1:0]     r_prod [LANES][3];

  logic [SW-1:0]            w_sum [LANES];
  logic [RW-1:0]            w_r   [LANES];
  logic [RW-1:0]            w_abs [LANES];
  logic [RW-1:0]            w_dsh;
  logic [RW-1:0]            w_thr;
  logic [LANES-1:0]         w_in;

  logic [PCW-1:0]           w_pc_in, w_pc_lv;
  logic [AW-1:0]            w_cnt_sum, w_tot_sum;
  logic                     w_ovf_c, w_ovf_t;

  logic [COUNT_WIDTH-1:0]   r_count, r_total;
  logic                     r_sat;

  // iready is forced low while reset is held, independent of the state register
  assign iready   = reset && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_accept = ivalid && iready;
  assign w_start  = w_accept && (r_state == S_IDLE);
  assign ovalid   = (r_state == S_DONE);
  assign count    = r_count;
  assign total    = r_total;
  assign saturated = r_sat;

  // Batch control FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= ilast ? S_DRAIN : S_RUN;
        S_RUN:   if (w_accept && ilast) r_state <= S_DRAIN;
        S_DRAIN: if (!(r_v0 || r_v1 || r_v2)) r_state <= S_DONE;
        S_DONE:  if (oacknowledge) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Plane registers, latched by the first beat of a batch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 3; k++) r_n[k] <= '0;
      r_d <= '0;
      r_t <= '0;
    end else if (w_start) begin
      for (int unsigned k = 0; k < 3; k++) r_n[k] <= n[k*WIDTH +: WIDTH];
      r_d <= d;
      r_t <= t;
    end
  end

  // Input capture stage: the plane is only valid in registers from the accept edge on
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v0  <= 1'b0;
      r_lv0 <= '0;
      r_p0  <= '0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_lv0 <= lane_valid;
        r_p0  <= p;
      end
    end
  end

  // Split captured points into signed coordinates
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++)
      for (int unsigned k = 0; k < 3; k++)
        w_pt[i][k] = r_p0[(i*3+k)*WIDTH +: WIDTH];
  end

  // S1: register the per-axis products
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v1  <= 1'b0;
      r_lv1 <= '0;
      for (int unsigned i = 0; i < LANES; i++)
        for (int unsigned k = 0; k < 3; k++) r_prod[i][k] <= '0;
    end else begin
      r_v1  <= r_v0;
      r_lv1 <= r_lv0;
      for (int unsigned i = 0; i < LANES; i++)
        for (int unsigned k = 0; k < 3; k++)
          r_prod[i][k] <= PW'(w_pt[i][k]) * PW'(r_n[k]);
    end
  end

  // Residual magnitude and exact inclusive threshold compare per lane
  always_comb begin
    w_dsh = {{(RW-WIDTH){r_d[WIDTH-1]}}, r_d} << FBITS;
    w_thr = {{(RW-WIDTH){1'b0}}, r_t} << FBITS;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_sum[i] = {{2{r_prod[i][0][PW-1]}}, r_prod[i][0]}
               + {{2{r_prod[i][1][PW-1]}}, r_prod[i][1]}
               + {{2{r_prod[i][2][PW-1]}}, r_prod[i][2]};
      w_r[i]   = {w_sum[i][SW-1], w_sum[i]} - w_dsh;
      w_abs[i] = w_r[i][RW-1] ? -w_r[i] : w_r[i];
      w_in[i]  = (w_abs[i] <= w_thr);
    end
  end

  // S2: register masked compare bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v2  <= 1'b0;
      r_lv2 <= '0;
      r_in2 <= '0;
    end else begin
      r_v2  <= r_v1;
      r_lv2 <= r_lv1;
      r_in2 <= w_in & r_lv1;
    end
  end

  // Popcounts and widened sums for saturation detection
  always_comb begin
    w_pc_in = '0;
    w_pc_lv = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_pc_in = w_pc_in + PCW'(r_in2[i]);
      w_pc_lv = w_pc_lv + PCW'(r_lv2[i]);
    end
    w_cnt_sum = AW'(r_count) + AW'(w_pc_in);
    w_tot_sum = AW'(r_total) + AW'(w_pc_lv);
    w_ovf_c   = (w_cnt_sum > AW'(CMAX));
    w_ovf_t   = (w_tot_sum > AW'(CMAX));
  end

  // S3: saturating accumulators, cleared when a new batch starts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_total <= '0;
      r_sat   <= 1'b0;
    end else if (w_start) begin
      r_count <= '0;
      r_total <= '0;
      r_sat   <= 1'b0;
    end else if (r_v2) begin
      r_count <= w_ovf_c ? CMAX : w_cnt_sum[COUNT_WIDTH-1:0];
      r_total <= w_ovf_t ? CMAX : w_tot_sum[COUNT_WIDTH-1:0];
      r_sat   <= r_sat | w_ovf_c | w_ovf_t;
    end
  end

endmodule

// File: tb/tb_count_inliers.sv
// Testbench for count_inliers: scoreboard of per-batch results from a real-valued model.
module tb_count_inliers;

  logic         clock = 1'b0;
  logic         reset;
  logic         ivalid, ilast, oacknowledge;
  logic [3:0]   lane_valid;
  logic [383:0] p;
  logic [95:0]  n;
  logic [31:0]  d, t;

  logic         iready, ovalid, saturated;
  logic [23:0]  count, total;
  logic         iready4, ovalid4, sat4;
  logic [3:0]   count4, total4;

  int checks;
  int errors;

  typedef struct {
    logic [23:0] c;
    logic [23:0] tt;
    logic        s;
    logic [3:0]  c4;
    logic [3:0]  t4;
    logic        s4;
  } exp_t;

  exp_t sb[$];

  // model state
  logic [95:0] m_n;
  logic [31:0] m_d, m_t;
  bit          m_busy;
  int          m_c, m_tot;

  count_inliers #(.LANES(4), .WIDTH(32), .FBITS(16), .COUNT_WIDTH(24)) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready), .ilast(ilast),
    .lane_valid(lane_valid), .p(p), .n(n), .d(d), .t(t), .ovalid(ovalid),
    .oacknowledge(oacknowledge), .count(count), .total(total), .saturated(saturated)
  );

  count_inliers #(.LANES(4), .WIDTH(32), .FBITS(16), .COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready4), .ilast(ilast),
    .lane_valid(lane_valid), .p(p), .n(n), .d(d), .t(t), .ovalid(ovalid4),
    .oacknowledge(oacknowledge), .count(count4), .total(total4), .saturated(sat4)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic real fx(input logic [31:0] v);
    int s;
    s = v;
    return $itor(s) / 65536.0;
  endfunction

  function automatic bit model_inlier(input logic [95:0] pt);
    real r;
    r = fx(m_n[31:0]) * fx(pt[31:0]) + fx(m_n[63:32]) * fx(pt[63:32])
      + fx(m_n[95:64]) * fx(pt[95:64]) - fx(m_d);
    if (r < 0.0) r = -r;
    return r <= fx(m_t);
  endfunction

  function automatic logic [383:0] pts_x(input logic [31:0] x0, x1, x2, x3);
    logic [383:0] v;
    v = '0;
    v[31:0]    = x0;
    v[127:96]  = x1;
    v[223:192] = x2;
    v[319:288] = x3;
    return v;
  endfunction

  task automatic set_plane0;
    n = {32'd0, 32'd0, 32'h0001_0000};
    d = 32'h0002_0000;
    t = 32'h0000_4000;
  endtask

  // Drive one beat until accepted; update the model and push a result at ilast
  task automatic send_beat(input logic [3:0] lv, input logic [383:0] pts,
                           input logic last, input bit randv);
    bit acc;
    int tries;
    exp_t e;
    acc = 0;
    tries = 0;
    while (!acc && tries < 500) begin
      @(negedge clock);
      ivalid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      ilast = last;
      lane_valid = lv;
      p = pts;
      #1;
      acc = ivalid && iready;
      @(posedge clock);
      #1 ivalid = 1'b0;
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", tries);
    end else begin
      if (!m_busy) begin
        m_n = n; m_d = d; m_t = t;
        m_c = 0; m_tot = 0; m_busy = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (lv[i]) begin
          m_tot++;
          if (model_inlier(pts[i*96 +: 96])) m_c++;
        end
      end
      if (last) begin
        e.c  = (m_c > 16777215) ? 24'hFFFFFF : 24'(m_c);
        e.tt = (m_tot > 16777215) ? 24'hFFFFFF : 24'(m_tot);
        e.s  = (m_c > 16777215) || (m_tot > 16777215);
        e.c4 = (m_c > 15) ? 4'hF : 4'(m_c);
        e.t4 = (m_tot > 15) ? 4'hF : 4'(m_tot);
        e.s4 = (m_c > 15) || (m_tot > 15);
        sb.push_back(e);
        m_busy = 0;
      end
    end
  endtask

  // Wait (bounded) for ovalid; lat counts falling edges since the accept edge
  task automatic await_result(output int lat, output int rdy);
    lat = 0;
    rdy = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (iready) rdy++;
      if (ovalid) break;
    end
  endtask

  task automatic do_ack;
    @(negedge clock);
    oacknowledge = 1'b1;
    @(posedge clock);
    #1 oacknowledge = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ivalid = 1'b0; ilast = 1'b0; oacknowledge = 1'b0;
    lane_valid = '0; p = '0; n = '0; d = '0; t = '0;
    m_busy = 0;
    #7;
    checks++;
    if ({iready, ovalid, count, total, saturated, iready4, ovalid4, count4, total4, sat4} !== '0) begin
      errors++;
      $display("FAIL reset.outputs got iready=%b ovalid=%b count=%0d total=%0d sat=%b count4=%0d want all 0",
               iready, ovalid, count, total, saturated, count4);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (iready !== 1'b1) begin
      errors++;
      $display("FAIL reset.iready_after got %b want 1", iready);
    end
  endtask

  task automatic test_single;
    int lat, rdy;
    exp_t e;
    set_plane0;
    send_beat(4'b1111, pts_x(32'h0002_4000, 32'h0001_C000, 32'h0002_4001, 32'hFFFE_0000), 1'b1, 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL single.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL single.latency got %0d falling edges want 5", lat); end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL single.iready_drain got %0d ready cycles want 0", rdy); end
    checks++;
    if ({count, total, saturated} !== {e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL single.result got %0d/%0d/%b want %0d/%0d/%b", count, total, saturated, e.c, e.tt, e.s);
    end
    checks++;
    if ({ovalid4, count4, total4, sat4} !== {1'b1, e.c4, e.t4, e.s4}) begin
      errors++;
      $display("FAIL single.result4 got %b %0d/%0d/%b want 1 %0d/%0d/%b", ovalid4, count4, total4, sat4, e.c4, e.t4, e.s4);
    end
    do_ack;
  endtask

  // oacknowledge held high throughout: must be ignored until ovalid rises
  task automatic test_partial;
    int lat, rdy;
    exp_t e;
    set_plane0;
    oacknowledge = 1'b1;
    send_beat(4'b0101, pts_x(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000), 1'b1, 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL partial.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL partial.latency got %0d falling edges want 5", lat); end
    checks++;
    if ({count, total, saturated} !== {e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL partial.result got %0d/%0d/%b want %0d/%0d/%b", count, total, saturated, e.c, e.tt, e.s);
    end
    @(posedge clock);
    #1 oacknowledge = 1'b0;
    checks++;
    if ({ovalid, iready} !== 2'b01) begin
      errors++;
      $display("FAIL partial.ack got ovalid=%b iready=%b want 0 1", ovalid, iready);
    end
  endtask

  task automatic test_saturation;
    int lat, rdy;
    exp_t e;
    set_plane0;
    for (int i = 0; i < 5; i++)
      send_beat(4'b1111, pts_x(32'h0002_0000, 32'h0002_1000, 32'h0001_F000, 32'h0002_4000), 1'(i == 4), 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL saturation.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if ({ovalid4, count4, total4, sat4} !== {1'b1, e.c4, e.t4, e.s4}) begin
      errors++;
      $display("FAIL saturation.narrow got %b %0d/%0d/%b want 1 %0d/%0d/%b", ovalid4, count4, total4, sat4, e.c4, e.t4, e.s4);
    end
    checks++;
    if ({count, total, saturated} !== {e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL saturation.wide got %0d/%0d/%b want %0d/%0d/%b", count, total, saturated, e.c, e.tt, e.s);
    end
    do_ack;
  endtask

  task automatic test_random;
    int lat, rdy, x, y;
    exp_t e;
    logic [383:0] pts;
    n = {32'd0, 32'h0000_CCCD, 32'h0000_999A};
    d = 32'h0000_8000;
    t = 32'h0001_0000;
    for (int i = 0; i < 1000; i++) begin
      for (int j = 0; j < 4; j++) begin
        x = int'($urandom_range(0, 262144)) - 131072;
        y = int'($urandom_range(0, 262144)) - 131072;
        pts[j*96 +: 32]      = x;
        pts[j*96 + 32 +: 32] = y;
        pts[j*96 + 64 +: 32] = $urandom;
      end
      send_beat(4'($urandom), pts, 1'(i == 999), 1);
      n = {$urandom, $urandom, $urandom};
      d = $urandom;
      t = $urandom;
    end
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL random.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL random.latency got %0d falling edges want 5", lat); end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL random.iready_drain got %0d ready cycles want 0", rdy); end
    checks++;
    if ({count, total, saturated} !== {e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL random.result got %0d/%0d/%b want %0d/%0d/%b", count, total, saturated, e.c, e.tt, e.s);
    end
    checks++;
    if ({count4, total4, sat4} !== {e.c4, e.t4, e.s4}) begin
      errors++;
      $display("FAIL random.result4 got %0d/%0d/%b want %0d/%0d/%b", count4, total4, sat4, e.c4, e.t4, e.s4);
    end
    do_ack;
  endtask

  task automatic test_back_to_back;
    int lat, rdy;
    exp_t e;
    set_plane0;
    send_beat(4'b1111, pts_x(32'h0002_4000, 32'h0001_C000, 32'h0002_4001, 32'hFFFE_0000), 1'b1, 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL hold.scoreboard empty"); return; end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({ovalid, iready, count, total, saturated} !== {1'b1, 1'b0, e.c, e.tt, e.s}) begin
        errors++;
        $display("FAIL hold.stable cycle %0d got ovalid=%b iready=%b %0d/%0d/%b want 1 0 %0d/%0d/%b",
                 i, ovalid, iready, count, total, saturated, e.c, e.tt, e.s);
      end
    end
    do_ack;
    checks++;
    if ({ovalid, iready} !== 2'b01) begin
      errors++;
      $display("FAIL hold.ack got ovalid=%b iready=%b want 0 1", ovalid, iready);
    end
    // all-lanes-invalid last beat, accepted on the first cycle back in IDLE
    send_beat(4'b0000, pts_x(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000), 1'b1, 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL b2b.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL b2b.latency got %0d falling edges want 5", lat); end
    checks++;
    if ({count, total, saturated} !== {e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL b2b.result got %0d/%0d/%b want %0d/%0d/%b", count, total, saturated, e.c, e.tt, e.s);
    end
    do_ack;
  endtask

  task automatic test_reset_midbatch;
    int lat, rdy;
    exp_t e;
    set_plane0;
    send_beat(4'b1111, pts_x(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000), 1'b0, 0);
    repeat (4) @(negedge clock);
    send_beat(4'b1111, pts_x(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000), 1'b0, 0);
    @(posedge clock);
    #2;
    checks++;
    if ({count, total} !== {24'd4, 24'd4}) begin
      errors++;
      $display("FAIL midreset.partial got %0d/%0d want 4/4", count, total);
    end
    reset = 1'b0;
    m_busy = 0;
    #1;
    checks++;
    if ({iready, ovalid, count, total, saturated, count4, total4, sat4} !== '0) begin
      errors++;
      $display("FAIL midreset.async got iready=%b ovalid=%b %0d/%0d/%b want all 0",
               iready, ovalid, count, total, saturated);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({iready, ovalid} !== 2'b10) begin
      errors++;
      $display("FAIL midreset.release got iready=%b ovalid=%b want 1 0", iready, ovalid);
    end
    send_beat(4'b0001, pts_x(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000), 1'b1, 0);
    await_result(lat, rdy);
    if (sb.size() == 0) begin errors++; $display("FAIL midreset.scoreboard empty"); return; end
    e = sb.pop_front();
    checks++;
    if ({ovalid, count, total, saturated} !== {1'b1, e.c, e.tt, e.s}) begin
      errors++;
      $display("FAIL midreset.next got ovalid=%b %0d/%0d/%b want 1 %0d/%0d/%b",
               ovalid, count, total, saturated, e.c, e.tt, e.s);
    end
    do_ack;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_partial();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_midbatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
